// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle-factor sequencer and other FFT blocks:
// FSM encoding, quarter-wave cosine ROM builder and quadrant sign mapping.
package twiddle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tw_state_t;

    // Quadrant mapping result: which ROM port feeds the real part and the
    // sign applied to each component. The imaginary part always takes the
    // other port, so the mapping is independent of the data width.
    typedef struct packed {
        logic swap;    // 1: re from c[N/4-r], im from c[r]
        logic re_neg;
        logic im_neg;
    } qmap_t;

    localparam real TW_PI = 3.14159265358979323846;

    // round(2^q_frac * cos(2*pi*idx/2^n_log2)) for idx in 0..N/4.
    // Taylor series keeps this a pure constant function for elaboration.
    function automatic int rom_cos(input int n_log2, input int q_frac, input int idx);
        real x;
        real term;
        real sum;
        x    = 2.0 * TW_PI * real'(idx) / real'(1 << n_log2);
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n <= 16; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        sum = sum * real'(1 << q_frac);
        if (sum < 0.0) begin
            return -$rtoi(-sum + 0.5);
        end
        return $rtoi(sum + 0.5);
    endfunction

    // Quarter-wave symmetry for W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N),
    // with optional conjugation for the inverse transform.
    function automatic qmap_t quad_map(input logic [1:0] q, input logic inv);
        qmap_t m;
        case (q)
            2'd0:    m = '{swap: 1'b0, re_neg: 1'b0, im_neg: 1'b1};
            2'd1:    m = '{swap: 1'b1, re_neg: 1'b1, im_neg: 1'b1};
            2'd2:    m = '{swap: 1'b0, re_neg: 1'b1, im_neg: 1'b0};
            default: m = '{swap: 1'b1, re_neg: 1'b0, im_neg: 1'b0};
        endcase
        if (inv) begin
            m.im_neg = ~m.im_neg;
        end
        return m;
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Registered quarter-wave cosine ROM with two read ports (r and N/4-r).
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter int N_LOG2  = 4,
    parameter int W_WIDTH = 16,
    parameter int Q_FRAC  = 14
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [N_LOG2-2:0]         addr_a,
    input  logic [N_LOG2-2:0]         addr_b,
    output logic signed [W_WIDTH-1:0] data_a,
    output logic signed [W_WIDTH-1:0] data_b
);
    localparam int QN = 1 << (N_LOG2 - 2);

    logic signed [W_WIDTH-1:0] rom [0:QN];

    for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
        localparam int CV = rom_cos(N_LOG2, Q_FRAC, gi);
        assign rom[gi] = CV[W_WIDTH-1:0];
    end

    // Both reads advance only when the output pipeline is enabled.
    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_seq.sv
// Sequenced twiddle-factor generator: streams W_N^(i*stride mod N) for
// i = 0..count-1 through a two-stage pipeline with valid/ready backpressure.
module twiddle_seq
    import twiddle_pkg::*;
#(
    parameter int N_LOG2  = 4,
    parameter int W_WIDTH = 16,
    parameter int Q_FRAC  = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_LOG2-1:0]         stride,
    input  logic [N_LOG2:0]           count,
    input  logic                      inv,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [W_WIDTH-1:0] out_re,
    output logic signed [W_WIDTH-1:0] out_im,
    output logic                      out_last,
    output logic                      done
);
    localparam int AW = N_LOG2 - 1;
    localparam int CW = N_LOG2 + 1;
    localparam int QN = 1 << (N_LOG2 - 2);
    localparam logic [AW-1:0] R_MASK = AW'(QN - 1);
    localparam logic [AW-1:0] QN_A   = AW'(QN);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    tw_state_t state, state_nx;

    logic [N_LOG2-1:0] stride_l;
    logic [CW-1:0]     count_l;
    logic              inv_l;
    logic [N_LOG2-1:0] k;
    logic [CW-1:0]     cnt;

    logic              en;
    logic              issue;
    logic              issue_last;
    logic [AW-1:0]     r_k;

    logic [1:0]        q_p1, q_p2;
    logic [AW-1:0]     r_p1;
    logic              last_p1, last_p2;
    logic              vld_p1, vld_p2;

    logic signed [W_WIDTH-1:0] c_r, c_nr;
    logic signed [W_WIDTH-1:0] re_mag, im_mag;
    qmap_t                     qm;

    assign en         = !vld_p2 || out_ready;
    assign issue      = (state == ST_RUN) && en;
    assign issue_last = issue && (cnt == count_l - ONE_C);
    assign r_k        = k[AW-1:0] & R_MASK;
    assign out_valid  = vld_p2;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic plus busy/done decode.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue_last) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (vld_p2 && out_ready && last_p2) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Command latch, exponent/issue counters and pipeline valids.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stride_l <= '0;
            count_l  <= '0;
            inv_l    <= 1'b0;
            k        <= '0;
            cnt      <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                stride_l <= stride;
                count_l  <= count;
                inv_l    <= inv;
                k        <= '0;
                cnt      <= '0;
            end else if (issue) begin
                k   <= k + stride_l;
                cnt <= cnt + ONE_C;
            end
            if (en) begin
                vld_p1 <= issue;
                vld_p2 <= vld_p1;
            end
        end
    end

    // ---- S1: quadrant, ROM offset and last tag ----
    always_ff @(posedge clk) begin
        if (en) begin
            q_p1    <= k[N_LOG2-1 -: 2];
            r_p1    <= r_k;
            last_p1 <= issue_last;
            q_p2    <= q_p1;
            last_p2 <= last_p1;
        end
    end

    // ---- S2: registered ROM reads for c[r] and c[N/4-r] ----
    twiddle_qrom #(
        .N_LOG2  (N_LOG2),
        .W_WIDTH (W_WIDTH),
        .Q_FRAC  (Q_FRAC)
    ) u_qrom (
        .clk    (clk),
        .en     (en),
        .addr_a (r_p1),
        .addr_b (QN_A - r_p1),
        .data_a (c_r),
        .data_b (c_nr)
    );

    // Sign mapping on the S2 ROM outputs; outputs read zero when no beat is held.
    always_comb begin
        qm       = quad_map(q_p2, inv_l);
        re_mag   = qm.swap ? c_nr : c_r;
        im_mag   = qm.swap ? c_r : c_nr;
        out_re   = '0;
        out_im   = '0;
        out_last = 1'b0;
        if (vld_p2) begin
            out_re   = qm.re_neg ? -re_mag : re_mag;
            out_im   = qm.im_neg ? -im_mag : im_mag;
            out_last = last_p2;
        end
    end

endmodule

// File: tb/tb_twiddle_seq.sv
// Testbench for twiddle_seq: default N=16 instance plus an N=64 instance.
module tb_twiddle_seq;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, inv, out_ready;
    logic [3:0]         stride;
    logic [4:0]         count;
    logic               busy, out_valid, out_last, done;
    logic signed [15:0] out_re, out_im;

    logic               start6, inv6, ready6;
    logic [5:0]         stride6;
    logic [6:0]         count6;
    logic               busy6, valid6, last6, done6;
    logic signed [17:0] re6, im6;

    twiddle_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .count(count),
        .inv(inv), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .done(done)
    );

    twiddle_seq #(.N_LOG2(6), .W_WIDTH(18), .Q_FRAC(16)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .stride(stride6), .count(count6),
        .inv(inv6), .busy(busy6), .out_valid(valid6), .out_ready(ready6),
        .out_re(re6), .out_im(im6), .out_last(last6), .done(done6)
    );

    typedef struct {
        int re;
        int im;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    got_re[64];
    int    got_im[64];

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden N=16 model: W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q14.
    task automatic push_model(input int st, input int cnt, input bit iv);
        int    kk;
        real   ang;
        beat_t b;
        kk = 0;
        for (int i = 0; i < cnt; i++) begin
            ang    = 2.0 * PI * real'(kk) / 16.0;
            b.re   = rnd(16384.0 * $cos(ang));
            b.im   = rnd(-16384.0 * $sin(ang));
            if (iv) b.im = -b.im;
            b.last = (i == cnt - 1);
            exp_q.push_back(b);
            kk = (kk + st) % 16;
        end
    endtask

    task automatic start_cmd(input int st, input int cnt, input bit iv);
        stride = 4'(st);
        count  = 5'(cnt);
        inv    = iv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Consume beats, comparing each against the scoreboard head and checking
    // that held beats do not change while stalled.
    task automatic drain(input int max_cycles, input bit rnd_ready, input int max_beats,
                         output int beats, output int done_at, output int last_hs);
        logic signed [31:0] a_re, a_im, p_re, p_im;
        logic               p_last;
        bit                 stalled;
        beat_t              e;
        beats   = 0;
        done_at = -1;
        last_hs = -1;
        stalled = 1'b0;
        p_re    = 0;
        p_im    = 0;
        p_last  = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            a_re = out_re;
            a_im = out_im;
            if (stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || a_re !== p_re || a_im !== p_im || out_last !== p_last) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d: got v=%b re=%0d im=%0d last=%b, want v=1 re=%0d im=%0d last=%b",
                             c, out_valid, a_re, a_im, out_last, p_re, p_im, p_last);
                end
            end
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat cyc %0d: got re=%0d im=%0d, want no beat", c, a_re, a_im);
                end else begin
                    e = exp_q[0];
                    if (a_re !== e.re || a_im !== e.im || out_last !== e.last) begin
                        errors++;
                        $display("FAIL beat_%0d: got (%0d,%0d,last=%b), want (%0d,%0d,last=%b)",
                                 beats, a_re, a_im, out_last, e.re, e.im, e.last);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (beats < 64) begin
                            got_re[beats] = a_re;
                            got_im[beats] = a_im;
                        end
                        if (e.last) last_hs = c;
                        beats++;
                    end
                end
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            p_re    = a_re;
            p_im    = a_im;
            p_last  = out_last;
            if (max_beats > 0 && beats == max_beats) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({out_valid, out_last, busy, done, out_re, out_im} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b last=%b busy=%b done=%b re=%0d im=%0d, want all 0",
                     out_valid, out_last, busy, done, out_re, out_im);
        end
        vectors++;
        if ({valid6, last6, busy6, done6, re6, im6} !== '0) begin
            errors++;
            $display("FAIL reset_outputs6: got v=%b busy=%b done=%b re=%0d im=%0d, want all 0",
                     valid6, busy6, done6, re6, im6);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int beats, done_at, last_hs;
        int ix[4] = '{0, 4, 5, 9};
        int er[4] = '{16384, 0, -6270, -15137};
        int ei[4] = '{0, -16384, -15137, 6270};
        out_ready = 1'b1;
        push_model(1, 10, 1'b0);
        start_cmd(1, 10, 1'b0);
        drain(100, 1'b0, 0, beats, done_at, last_hs);
        vectors++;
        if (beats !== 10) begin
            errors++;
            $display("FAIL basic_beats: got %0d, want 10", beats);
        end
        vectors++;
        if (done_at < 0 || done_at !== last_hs + 1) begin
            errors++;
            $display("FAIL basic_done_timing: got done at %0d, want %0d", done_at, last_hs + 1);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_re[ix[i]] !== er[i] || got_im[ix[i]] !== ei[i]) begin
                errors++;
                $display("FAIL basic_const_beat%0d: got (%0d,%0d), want (%0d,%0d)",
                         ix[i], got_re[ix[i]], got_im[ix[i]], er[i], ei[i]);
            end
        end
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_in_done: got %b, want 1", busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_idle: got done=%b busy=%b left=%0d, want 0 0 0", done, busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_inverse();
        int beats, done_at, last_hs;
        int er[4] = '{16384, 0, -16384, 0};
        int ei[4] = '{0, 16384, 0, -16384};
        out_ready = 1'b1;
        push_model(4, 4, 1'b1);
        start_cmd(4, 4, 1'b1);
        drain(100, 1'b0, 0, beats, done_at, last_hs);
        vectors++;
        if (beats !== 4 || done_at !== last_hs + 1) begin
            errors++;
            $display("FAIL inv_beats: got %0d beats done_at %0d, want 4 beats done_at %0d", beats, done_at, last_hs + 1);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_re[i] !== er[i] || got_im[i] !== ei[i]) begin
                errors++;
                $display("FAIL inv_const_beat%0d: got (%0d,%0d), want (%0d,%0d)",
                         i, got_re[i], got_im[i], er[i], ei[i]);
            end
        end
        tick();
        exp_q.delete();
    endtask

    task automatic test_stall();
        int beats, done_at, last_hs;
        out_ready = 1'b1;
        push_model(1, 16, 1'b0);
        start_cmd(1, 16, 1'b0);
        drain(400, 1'b1, 0, beats, done_at, last_hs);
        vectors++;
        if (beats !== 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_handshakes: got %0d (left %0d), want 16 (left 0)", beats, exp_q.size());
        end
        vectors++;
        if (done_at < 0 || done_at !== last_hs + 1) begin
            errors++;
            $display("FAIL stall_done_timing: got %0d, want %0d", done_at, last_hs + 1);
        end
        out_ready = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic test_zero_count();
        out_ready = 1'b1;
        start_cmd(3, 0, 1'b0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b v=%b, want 1 1 0", done, busy, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_idle_%0d: got done=%b busy=%b v=%b, want 0 0 0", i, done, busy, out_valid);
            end
        end
    endtask

    task automatic test_start_ignored();
        int beats, done_at, last_hs;
        out_ready = 1'b1;
        push_model(1, 6, 1'b0);
        start_cmd(1, 6, 1'b0);
        stride = 4'd3;
        count  = 5'd2;
        inv    = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        drain(100, 1'b0, 0, beats, done_at, last_hs);
        vectors++;
        if (beats !== 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_beats: got %0d, want 6", beats);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_quiet_%0d: got v=%b busy=%b, want 0 0", i, out_valid, busy);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int beats, done_at, last_hs;
        out_ready = 1'b1;
        push_model(1, 10, 1'b0);
        start_cmd(1, 10, 1'b0);
        drain(100, 1'b0, 4, beats, done_at, last_hs);
        vectors++;
        if (beats !== 4) begin
            errors++;
            $display("FAIL rstmid_pre_beats: got %0d, want 4", beats);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({out_valid, out_last, busy, done, out_re, out_im} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b last=%b busy=%b done=%b re=%0d im=%0d, want all 0",
                     out_valid, out_last, busy, done, out_re, out_im);
        end
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_resume: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
        push_model(1, 10, 1'b0);
        start_cmd(1, 10, 1'b0);
        drain(100, 1'b0, 0, beats, done_at, last_hs);
        vectors++;
        if (beats !== 10 || got_re[0] !== 16384 || got_im[0] !== 0) begin
            errors++;
            $display("FAIL rstmid_restart: got %0d beats first (%0d,%0d), want 10 beats first (16384,0)",
                     beats, got_re[0], got_im[0]);
        end
        tick();
        exp_q.delete();
    endtask

    task automatic test_large();
        int                 b, d;
        logic signed [31:0] a_re, a_im;
        int                 e_re, e_im;
        real                ang;
        b = 0;
        stride6 = 6'd1;
        count6  = 7'd64;
        inv6    = 1'b0;
        start6  = 1'b1;
        tick();
        start6  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done6 === 1'b1) break;
            if (valid6 === 1'b1) begin
                a_re = re6;
                a_im = im6;
                ang  = 2.0 * PI * real'(b) / 64.0;
                e_re = rnd(65536.0 * $cos(ang));
                e_im = rnd(-65536.0 * $sin(ang));
                vectors++;
                d = (a_re - e_re > 0) ? a_re - e_re : e_re - a_re;
                if ($isunknown({re6, im6, last6}) || d > 1 ||
                    ((a_im - e_im > 0) ? a_im - e_im : e_im - a_im) > 1 || last6 !== (b == 63)) begin
                    errors++;
                    $display("FAIL n64_beat_%0d: got (%0d,%0d,last=%b), want (%0d,%0d,last=%b) within 1 LSB",
                             b, a_re, a_im, last6, e_re, e_im, (b == 63));
                end
                b++;
            end
            tick();
        end
        vectors++;
        if (b !== 64 || done6 !== 1'b1) begin
            errors++;
            $display("FAIL n64_count: got %0d beats done=%b, want 64 beats done=1", b, done6);
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stride    = '0;
        count     = '0;
        inv       = 1'b0;
        out_ready = 1'b1;
        start6    = 1'b0;
        stride6   = '0;
        count6    = '0;
        inv6      = 1'b0;
        ready6    = 1'b1;
        test_reset();
        test_basic();
        test_inverse();
        test_stall();
        test_zero_count();
        test_start_ignored();
        test_reset_mid();
        test_large();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
